// File: rtl/range_store.sv
//==============================================================================
// Module      : range_store
// Description : Small CAM of inclusive address ranges with round-robin
//               replacement and a combinational newest-hit-wins lookup.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module range_store #(
   parameter int DEPTH = 8,
   parameter int AW    = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     en_write_i,
   input  logic [AW-1:0]            addr_first_i,
   input  logic [AW-1:0]            addr_last_i,
   input  logic [AW-1:0]            find_addr_i,
   output logic                     addr_in_range_o,
   output logic [$clog2(DEPTH)-1:0] hit_idx_o,
   output logic [AW-1:0]            read_o,
   output logic [AW-1:0]            read2_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     overwrite_o
);

   localparam int            IW         = $clog2(DEPTH);
   localparam logic [IW:0]   c_FULL_CNT = (IW+1)'(DEPTH);

   logic [DEPTH-1:0] r_valid;
   logic [AW-1:0]    r_first [DEPTH];
   logic [AW-1:0]    r_last  [DEPTH];
   logic [IW-1:0]    r_wr_ptr;
   logic [IW:0]      r_cnt;
   logic             r_overwrite;

   logic             w_full;
   logic             w_dup;
   logic             w_accept;
   logic             w_hit;
   logic [IW-1:0]    w_hit_idx;
   logic [IW-1:0]    w_slot;
   logic [IW-1:0]    w_newest;

   assign w_full = (r_cnt == c_FULL_CNT);

   always_comb begin
      w_dup = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_first[i] == addr_first_i) && (r_last[i] == addr_last_i))
            w_dup = 1'b1;
      end
   end

   assign w_accept = en_write_i && !clr_i && (addr_first_i <= addr_last_i) && !w_dup;

   // Walk slots from oldest (wr_ptr) to newest so the latest hit overrides earlier ones.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_slot    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_slot = r_wr_ptr + IW'(k);
         if (r_valid[w_slot] && (r_first[w_slot] <= find_addr_i) &&
             (find_addr_i <= r_last[w_slot])) begin
            w_hit     = 1'b1;
            w_hit_idx = w_slot;
         end
      end
   end

   assign w_newest = r_wr_ptr - IW'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid     <= '0;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
         r_overwrite <= 1'b0;
      end else if (clr_i) begin
         r_valid     <= '0;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
         r_overwrite <= 1'b0;
      end else begin
         r_overwrite <= w_accept && w_full;
         if (w_accept) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + IW'(1);
            if (!w_full)
               r_cnt <= r_cnt + (IW+1)'(1);
         end
      end
   end

   // Range data needs no reset: the valid bits gate every output.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_first[r_wr_ptr] <= addr_first_i;
         r_last[r_wr_ptr]  <= addr_last_i;
      end
   end

   assign addr_in_range_o = w_hit;
   assign hit_idx_o       = w_hit_idx;
   assign read_o          = (r_cnt != '0) ? r_first[w_newest] : '0;
   assign read2_o         = (r_cnt != '0) ? r_last[w_newest]  : '0;
   assign count_o         = r_cnt;
   assign full_o          = w_full;
   assign overwrite_o     = r_overwrite;

endmodule

`default_nettype wire

// File: tb/tb_range_store.sv
//==============================================================================
// Module      : tb_range_store
// Description : Directed bench for range_store with a queue-based range model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_range_store;

   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int IW    = $clog2(DEPTH);

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          clr_i = 1'b0;
   logic          en_write_i = 1'b0;
   logic [AW-1:0] addr_first_i = '0;
   logic [AW-1:0] addr_last_i = '0;
   logic [AW-1:0] find_addr_i = '0;
   logic          addr_in_range_o;
   logic [IW-1:0] hit_idx_o;
   logic [AW-1:0] read_o;
   logic [AW-1:0] read2_o;
   logic [IW:0]   count_o;
   logic          full_o;
   logic          overwrite_o;

   int n_tests = 0;
   int n_fail  = 0;

   range_store #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_write_i(en_write_i),
      .addr_first_i(addr_first_i), .addr_last_i(addr_last_i),
      .find_addr_i(find_addr_i), .addr_in_range_o(addr_in_range_o),
      .hit_idx_o(hit_idx_o), .read_o(read_o), .read2_o(read2_o),
      .count_o(count_o), .full_o(full_o), .overwrite_o(overwrite_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: ranges held oldest-first in a queue; slot index tracked by write total.
   typedef struct {
      logic [AW-1:0] f;
      logic [AW-1:0] l;
   } ent_t;

   ent_t q[$];
   int   m_ptr = 0;
   bit   m_ovw = 0;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i || clr_i) begin
         q.delete();
         m_ptr = 0;
         m_ovw = 0;
      end else begin
         bit dup;
         dup   = 0;
         m_ovw = 0;
         foreach (q[i]) if (q[i].f == addr_first_i && q[i].l == addr_last_i) dup = 1;
         if (en_write_i && addr_first_i <= addr_last_i && !dup) begin
            if (q.size() == DEPTH) begin
               q.delete(0);
               m_ovw = 1;
            end
            q.push_back('{addr_first_i, addr_last_i});
            m_ptr = (m_ptr + 1) % DEPTH;
         end
      end
   end

   always @(negedge clk_i) begin
      bit hit;
      int idx;
      hit = 0;
      idx = 0;
      foreach (q[i]) begin
         if (q[i].f <= find_addr_i && find_addr_i <= q[i].l) begin
            hit = 1;
            idx = (m_ptr - q.size() + i + DEPTH) % DEPTH;
         end
      end
      chk("cyc_hit",   64'(addr_in_range_o), 64'(hit));
      chk("cyc_idx",   64'(hit_idx_o), 64'(idx));
      chk("cyc_count", 64'(count_o), 64'(q.size()));
      chk("cyc_full",  64'(full_o), 64'(q.size() == DEPTH));
      chk("cyc_ovw",   64'(overwrite_o), 64'(m_ovw));
      chk("cyc_read",  64'(read_o),  (q.size() > 0) ? 64'(q[q.size()-1].f) : 64'h0);
      chk("cyc_read2", 64'(read2_o), (q.size() > 0) ? 64'(q[q.size()-1].l) : 64'h0);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] f, input logic [AW-1:0] l);
      en_write_i   = 1'b1;
      addr_first_i = f;
      addr_last_i  = l;
      tick();
      en_write_i   = 1'b0;
   endtask

   task automatic clear();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
   endtask

   task automatic look(input string nm, input logic [AW-1:0] a, input logic eh, input int ei);
      find_addr_i = a;
      #1;
      chk({nm, "_hit"}, 64'(addr_in_range_o), 64'(eh));
      chk({nm, "_idx"}, 64'(hit_idx_o), 64'(ei));
   endtask

   initial begin
      tick();
      tick();
      chk("rst_count", 64'(count_o), 64'h0);
      chk("rst_full",  64'(full_o), 64'h0);
      chk("rst_read",  64'(read_o), 64'h0);
      rst_i = 1'b0;

      // Single write
      wr(32'h1000, 32'h1020);
      look("sw_lo",   32'h1000, 1'b1, 0);
      look("sw_hi",   32'h1020, 1'b1, 0);
      look("sw_below", 32'h0FFF, 1'b0, 0);
      look("sw_above", 32'h1021, 1'b0, 0);
      chk("sw_read",  64'(read_o),  64'h1000);
      chk("sw_read2", 64'(read2_o), 64'h1020);
      chk("sw_count", 64'(count_o), 64'h1);

      // Drop rules
      wr(32'h2000, 32'h1FFF);
      chk("drop_inv_count", 64'(count_o), 64'h1);
      wr(32'h1000, 32'h1020);
      chk("drop_dup_count", 64'(count_o), 64'h1);
      clear();
      chk("clr_count", 64'(count_o), 64'h0);

      // Overlap priority
      wr(32'h100, 32'h200);
      wr(32'h180, 32'h300);
      look("ovl_190", 32'h190, 1'b1, 1);
      look("ovl_150", 32'h150, 1'b1, 0);
      clear();

      // Fill and wrap
      for (int i = 0; i < 8; i++) wr(32'h10000 + i * 32'h100, 32'h10080 + i * 32'h100);
      chk("fill_full",  64'(full_o), 64'h1);
      chk("fill_ovw0",  64'(overwrite_o), 64'h0);
      wr(32'h10800, 32'h10880);
      chk("wrap_ovw",   64'(overwrite_o), 64'h1);
      chk("wrap_count", 64'(count_o), 64'h8);
      tick();
      chk("wrap_ovw_end", 64'(overwrite_o), 64'h0);
      look("wrap_r0", 32'h10000, 1'b0, 0);
      look("wrap_r8", 32'h10840, 1'b1, 0);
      look("wrap_r1", 32'h10100, 1'b1, 1);
      chk("wrap_read", 64'(read_o), 64'h10800);
      clear();

      // Same-cycle visibility
      en_write_i = 1'b1; addr_first_i = 32'h40; addr_last_i = 32'h50;
      look("same_cyc", 32'h48, 1'b0, 0);
      tick();
      en_write_i = 1'b0;
      look("next_cyc", 32'h48, 1'b1, 0);

      // Clear beats a simultaneous write
      clr_i = 1'b1; en_write_i = 1'b1; addr_first_i = 32'h60; addr_last_i = 32'h70;
      tick();
      clr_i = 1'b0; en_write_i = 1'b0;
      chk("clrw_count", 64'(count_o), 64'h0);
      look("clrw_48", 32'h48, 1'b0, 0);
      look("clrw_65", 32'h65, 1'b0, 0);

      // Asynchronous reset between edges, write accepted as reset releases
      wr(32'h500, 32'h510);
      wr(32'h600, 32'h610);
      wr(32'h700, 32'h710);
      find_addr_i = 32'h705;
      chk("pre_rst_count", 64'(count_o), 64'h3);
      #1;
      rst_i = 1'b1;
      #1;
      chk("arst_hit",   64'(addr_in_range_o), 64'h0);
      chk("arst_idx",   64'(hit_idx_o), 64'h0);
      chk("arst_read",  64'(read_o), 64'h0);
      chk("arst_read2", 64'(read2_o), 64'h0);
      chk("arst_count", 64'(count_o), 64'h0);
      chk("arst_full",  64'(full_o), 64'h0);
      chk("arst_ovw",   64'(overwrite_o), 64'h0);
      rst_i = 1'b0;
      en_write_i = 1'b1; addr_first_i = 32'hA00; addr_last_i = 32'hA10;
      tick();
      en_write_i = 1'b0;
      chk("post_rst_count", 64'(count_o), 64'h1);
      look("post_rst_new", 32'hA05, 1'b1, 0);
      look("post_rst_old", 32'h705, 1'b0, 0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/range_store.md
RANGE_STORE -- requirements
Module: range_store

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of range entries; legal values are powers of two from 2 to 32.
REQ-002 The block SHALL have parameter AW, default 32, giving the address width.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 clr_i  input  1  synchronous flush of all entries.
REQ-006 en_write_i  input  1  single-cycle write request for one range.
REQ-007 addr_first_i  input  AW  inclusive start address of the range being written.
REQ-008 addr_last_i  input  AW  inclusive end address of the range being written.
REQ-009 find_addr_i  input  AW  lookup address.
REQ-010 addr_in_range_o  output  1  lookup hit flag.
REQ-011 hit_idx_o  output  $clog2(DEPTH)  index of the hitting entry.
REQ-012 read_o  output  AW  addr_first of the most recently written entry.
REQ-013 read2_o  output  AW  addr_last of the most recently written entry.
REQ-014 count_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-015 full_o  output  1  high when count_o equals DEPTH.
REQ-016 overwrite_o  output  1  one-cycle pulse when a write evicts a valid entry.

Function
REQ-017 Storage SHALL be DEPTH entries, each holding {valid, first[AW], last[AW]}, plus a write pointer wr_ptr and a counter cnt.
REQ-018 When en_write_i=1 and first<=last (unsigned) and no valid entry equals {first,last}, the block SHALL write entry[wr_ptr] on the next edge as follows:
- set valid=1;
- increment wr_ptr modulo DEPTH, wrapping from DEPTH-1 to 0;
- increment cnt, saturating at DEPTH.
REQ-019 A write with first>last SHALL be dropped with no state change.
REQ-020 A write that duplicates an existing valid entry SHALL be dropped with no state change.
REQ-021 A write while cnt==DEPTH SHALL overwrite the oldest entry (the entry at wr_ptr), leave cnt at DEPTH, and pulse overwrite_o high in the following cycle.
REQ-022 Lookup SHALL be combinational and zero-latency.
- addr_in_range_o=1 iff some valid entry satisfies first<=find_addr_i<=last (unsigned, both bounds inclusive).
REQ-023 On multiple hits, hit_idx_o SHALL report the most recently written hitting entry; when there is no hit, hit_idx_o SHALL be 0.
REQ-024 A write SHALL NOT be visible to lookup in the same cycle; it becomes visible from the cycle after the edge that captures it.
REQ-025 read_o/read2_o SHALL show the entry at (wr_ptr-1) mod DEPTH when cnt>0, and 0 otherwise.
REQ-026 clr_i=1 SHALL, on the next edge:
- clear all valid bits;
- set wr_ptr=0 and cnt=0;
- ignore any same-cycle en_write_i (clear has priority).
REQ-027 Entry data fields SHALL NOT be required to clear on clr_i; the valid bits alone gate all outputs.
REQ-028 full_o SHALL be derived combinationally from cnt.

Reset
REQ-029 While rst_i=1, and immediately on its assertion, the block SHALL force the following, independent of clk_i:
- all valid bits = 0;
- wr_ptr = 0 and cnt = 0;
- overwrite_o = 0.
REQ-030 Consequently during reset: addr_in_range_o=0, hit_idx_o=0, read_o=read2_o=0, count_o=0, full_o=0.
REQ-031 A write presented in the cycle rst_i deasserts SHALL be accepted normally.
REQ-032 Reset asserted mid-sequence SHALL discard all stored ranges; no partial entry may survive.

Verification
REQ-033 Single write: write {0x1000,0x1020} -> next cycle:
- find 0x1000, 0x1020 -> hit, idx 0;
- find 0x0FFF, 0x1021 -> miss;
- read_o=0x1000, read2_o=0x1020, count_o=1.
REQ-034 Fill and wrap (DEPTH=8): write 9 distinct ranges R0..R8 ->
- full_o=1 after R7;
- overwrite_o pulses once after R8;
- R0 addresses miss, R8 hits at idx 0, count_o=8.
REQ-035 Drop rules:
- write {0x2000,0x1FFF} -> no change;
- write {0x1000,0x1020} twice -> count_o=1.
REQ-036 Overlap priority: write {0x100,0x200} then {0x180,0x300}; find 0x190 -> hit, idx 1.
REQ-037 Same-cycle visibility and clear:
- write {0x40,0x50} with find 0x48 in the same cycle -> miss that cycle, hit the next;
- assert clr_i together with en_write_i -> count_o=0 and no hit.
REQ-038 Async reset: hold 3 entries, pulse rst_i between clock edges -> all outputs 0 before the next edge; the first post-reset write lands at idx 0.
